// File: rtl/bht_lh_pipe_pkg.sv
// Shared definitions for the local-history branch history table.
// Optional feature macro: BHT_PARITY_EN (per-entry even parity).
package bht_pkg;

    localparam int IDX_W_DEF  = 10;
    localparam int HIST_W_DEF = 10;
    localparam int GRP_W_DEF  = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } bht_state_e;

    // Shift the confirmed direction in at the LSB. Callers zero-extend the
    // history to 32 bits and truncate the result back to their own width.
    function automatic logic [31:0] hist_shift(input logic [31:0] hist, input logic dir);
        hist_shift = {hist[30:0], dir};
    endfunction

    // Even parity over a zero-extended value.
    function automatic logic even_par(input logic [31:0] val);
        even_par = ^val;
    endfunction

endpackage

// File: rtl/bht_lh_pipe_if.sv
// Request/response bundle for bht_lh_pipe.
// Optional feature macro: BHT_PARITY_EN adds perr_inj_i / rd_perr_o.
interface bht_lh_pipe_if
    import bht_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int HIST_W = HIST_W_DEF
) ();
    logic              rd_vld_i;
    logic [IDX_W-1:0]  rd_index_i;
    logic [HIST_W-1:0] rd_hist_o;
    logic              rd_hist_vld_o;
    logic              wt_en_i;
    logic [IDX_W-1:0]  wt_index_i;
    logic              wt_brdir_i;
    logic              flush_i;
    logic              busy_o;
`ifdef BHT_PARITY_EN
    logic              perr_inj_i;
    logic              rd_perr_o;
`endif

    modport master (
        output rd_vld_i, rd_index_i, wt_en_i, wt_index_i, wt_brdir_i, flush_i,
`ifdef BHT_PARITY_EN
        output perr_inj_i,
        input  rd_perr_o,
`endif
        input  rd_hist_o, rd_hist_vld_o, busy_o
    );

    modport slave (
        input  rd_vld_i, rd_index_i, wt_en_i, wt_index_i, wt_brdir_i, flush_i,
`ifdef BHT_PARITY_EN
        input  perr_inj_i,
        output rd_perr_o,
`endif
        output rd_hist_o, rd_hist_vld_o, busy_o
    );
endinterface

// File: rtl/bht_lh_pipe_grp.sv
// One write-enable group of the BHT: 2**GRP_W history entries with a local
// shift-in write port, a whole-group clear and an unregistered read port
// that the top muxes and registers.
// Optional feature macro: BHT_PARITY_EN stores a parity bit at bit HIST_W.
module bht_grp
    import bht_pkg::*;
#(
    parameter int GRP_W  = GRP_W_DEF,
    parameter int HIST_W = HIST_W_DEF,
    parameter int ENT_W  = HIST_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_wt_en,
    input  logic [GRP_W-1:0] i_wt_off,
    input  logic             i_wt_dir,
`ifdef BHT_PARITY_EN
    input  logic             i_perr_inj,
`endif
    input  logic             i_clr,
    input  logic [GRP_W-1:0] i_rd_off,
    output logic [ENT_W-1:0] o_rd_ent
);
    localparam int NENT = 2**GRP_W;

    logic [ENT_W-1:0]  r_mem [NENT];
    logic [HIST_W-1:0] w_new_hist;
    logic [ENT_W-1:0]  w_new_ent;

    assign w_new_hist = HIST_W'(hist_shift(32'(r_mem[i_wt_off][HIST_W-1:0]), i_wt_dir));
`ifdef BHT_PARITY_EN
    assign w_new_ent  = {even_par(32'(w_new_hist)) ^ i_perr_inj, w_new_hist};
`else
    assign w_new_ent  = w_new_hist;
`endif
    assign o_rd_ent   = r_mem[i_rd_off];

    // Entry storage: reset/clear zero the whole group, a write shifts one entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NENT; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < NENT; i++) r_mem[i] <= '0;
        end else if (i_wt_en) begin
            r_mem[i_wt_off] <= w_new_ent;
        end
    end
endmodule

// File: rtl/bht_lh_pipe.sv
// Local-history BHT: registered one-cycle read with same-cycle write bypass,
// commit-side shift-in writes and a group-at-a-time flush sequencer.
// Optional feature macro: BHT_PARITY_EN (per-entry even parity, rd_perr_o).
module bht_lh_pipe
    import bht_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int HIST_W = HIST_W_DEF,
    parameter int GRP_W  = GRP_W_DEF
) (
    input logic          clock,
    input logic          reset_n,
    bht_lh_pipe_if.slave bus
);
    localparam int CNT_W = IDX_W - GRP_W;
    localparam int NGRP  = 2**CNT_W;
`ifdef BHT_PARITY_EN
    localparam int ENT_W = HIST_W + 1;
`else
    localparam int ENT_W = HIST_W;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGRP - 1);

    bht_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_clr_en;
    logic              w_rd_acc, w_wt_acc, w_byp_hit;
    logic [CNT_W-1:0]  w_wt_grp, w_rd_grp;
    logic [ENT_W-1:0]  w_grp_rd [NGRP];
    logic [ENT_W-1:0]  w_rd_ent;
    logic [HIST_W-1:0] w_byp_hist, w_sel_hist;
    logic [HIST_W-1:0] r_rd_hist;
    logic              r_rd_vld;
`ifdef BHT_PARITY_EN
    logic              w_sel_perr;
    logic              r_rd_perr;
`endif

    // Requests are only honoured in IDLE; a flush in the same cycle kills the write.
    assign w_rd_acc  = (r_state == ST_IDLE) && bus.rd_vld_i;
    assign w_wt_acc  = (r_state == ST_IDLE) && bus.wt_en_i && !bus.flush_i;
    assign w_wt_grp  = bus.wt_index_i[IDX_W-1:GRP_W];
    assign w_rd_grp  = bus.rd_index_i[IDX_W-1:GRP_W];
    assign w_byp_hit = w_wt_acc && (bus.wt_index_i == bus.rd_index_i);

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        bht_grp #(.GRP_W(GRP_W), .HIST_W(HIST_W), .ENT_W(ENT_W)) u_grp (
            .clock      (clock),
            .reset_n    (reset_n),
            .i_wt_en    (w_wt_acc && (w_wt_grp == CNT_W'(g))),
            .i_wt_off   (bus.wt_index_i[GRP_W-1:0]),
            .i_wt_dir   (bus.wt_brdir_i),
`ifdef BHT_PARITY_EN
            .i_perr_inj (bus.perr_inj_i),
`endif
            .i_clr      (w_clr_en && (r_cnt == CNT_W'(g))),
            .i_rd_off   (bus.rd_index_i[GRP_W-1:0]),
            .o_rd_ent   (w_grp_rd[g])
        );
    end

    assign w_rd_ent   = w_grp_rd[w_rd_grp];
    assign w_byp_hist = HIST_W'(hist_shift(32'(w_rd_ent[HIST_W-1:0]), bus.wt_brdir_i));

    // Read data select: a same-index write wins so the read sees the post-update history.
    always_comb begin
        w_sel_hist = w_rd_ent[HIST_W-1:0];
`ifdef BHT_PARITY_EN
        w_sel_perr = even_par(32'(w_rd_ent[HIST_W-1:0])) ^ w_rd_ent[HIST_W];
`endif
        if (w_byp_hit) begin
            w_sel_hist = w_byp_hist;
`ifdef BHT_PARITY_EN
            // Freshly written parity mismatches only when an error is injected.
            w_sel_perr = bus.perr_inj_i;
`endif
        end else begin
            w_sel_hist = w_rd_ent[HIST_W-1:0];
        end
    end

    // Flush sequencer next-state: one group cleared per CLEAR cycle, restartable.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.flush_i) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_clr_en = 1'b1;
                if (bus.flush_i) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Flush sequencer state and group counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered read response; history holds when no read is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_hist <= '0;
            r_rd_vld  <= 1'b0;
`ifdef BHT_PARITY_EN
            r_rd_perr <= 1'b0;
`endif
        end else if (w_rd_acc) begin
            r_rd_vld  <= 1'b1;
`ifdef BHT_PARITY_EN
            r_rd_perr <= w_sel_perr;
            r_rd_hist <= w_sel_perr ? '0 : w_sel_hist;
`else
            r_rd_hist <= w_sel_hist;
`endif
        end else begin
            r_rd_vld  <= 1'b0;
`ifdef BHT_PARITY_EN
            r_rd_perr <= 1'b0;
`endif
        end
    end

    assign bus.rd_hist_o     = r_rd_hist;
    assign bus.rd_hist_vld_o = r_rd_vld;
    assign bus.busy_o        = (r_state == ST_CLEAR);
`ifdef BHT_PARITY_EN
    assign bus.rd_perr_o     = r_rd_perr;
`endif
endmodule

// File: tb/tb_bht_lh_pipe.sv
// Self-checking bench for bht_lh_pipe (default 1024x10, 32 groups).
// Optional feature macro: BHT_PARITY_EN enables the parity scenario.
module tb_bht_lh_pipe;
    import bht_pkg::*;

    localparam int IDX_W  = 10;
    localparam int HIST_W = 10;

    logic clock;
    logic reset_n;

    bht_lh_pipe_if #(.IDX_W(IDX_W), .HIST_W(HIST_W)) bus ();

    bht_lh_pipe #(.IDX_W(IDX_W), .HIST_W(HIST_W), .GRP_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int                n_checks = 0;
    int                n_errors = 0;
    logic [HIST_W-1:0] exp_q [$];
    logic [HIST_W-1:0] model [1024];

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_write(input logic [IDX_W-1:0] idx, input logic dir);
        bus.wt_en_i    = 1'b1;
        bus.wt_index_i = idx;
        bus.wt_brdir_i = dir;
        tick();
        bus.wt_en_i    = 1'b0;
    endtask

    task automatic drive_read(input logic [IDX_W-1:0] idx, input logic [HIST_W-1:0] exp_hist);
        bus.rd_vld_i   = 1'b1;
        bus.rd_index_i = idx;
        exp_q.push_back(exp_hist);
        tick();
        bus.rd_vld_i   = 1'b0;
    endtask

    task automatic test_reset();
        logic [HIST_W-1:0] e;
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.rd_hist_vld_o !== 1'b0 || bus.rd_hist_o !== 10'h000) begin
            n_errors++;
            $display("FAIL reset_state busy=%b vld=%b hist=%h expected 0 0 000",
                     bus.busy_o, bus.rd_hist_vld_o, bus.rd_hist_o);
        end
        tick();
        reset_n = 1'b1;
        tick();
        drive_read(10'd5, 10'h000);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.rd_hist_vld_o !== 1'b1 || bus.rd_hist_o !== e) begin
            n_errors++;
            $display("FAIL read_after_reset vld=%b hist=%h expected 1 %h", bus.rd_hist_vld_o, bus.rd_hist_o, e);
        end
    endtask

    task automatic test_write_read();
        logic [IDX_W-1:0]  idx_t [3] = '{10'd37, 10'd6, 10'd5};
        logic [HIST_W-1:0] exp_t [3] = '{10'h000, 10'h000, 10'h006};
        logic [HIST_W-1:0] e;
        drive_write(10'd5, 1'b1);
        drive_write(10'd5, 1'b1);
        drive_write(10'd5, 1'b0);
        // back-to-back reads across same and other groups
        for (int i = 0; i < 3; i++) begin
            bus.rd_vld_i   = 1'b1;
            bus.rd_index_i = idx_t[i];
            exp_q.push_back(exp_t[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (bus.rd_hist_vld_o !== 1'b1 || bus.rd_hist_o !== e) begin
                n_errors++;
                $display("FAIL read_idx%0d vld=%b hist=%h expected 1 %h", idx_t[i], bus.rd_hist_vld_o, bus.rd_hist_o, e);
            end
        end
        bus.rd_vld_i = 1'b0;
        tick();
        n_checks++;
        if (bus.rd_hist_vld_o !== 1'b0 || bus.rd_hist_o !== 10'h006) begin
            n_errors++;
            $display("FAIL read_hold vld=%b hist=%h expected 0 006", bus.rd_hist_vld_o, bus.rd_hist_o);
        end
    endtask

    task automatic test_bypass();
        logic [HIST_W-1:0] e;
        drive_write(10'd9, 1'b1);
        bus.wt_en_i    = 1'b1;
        bus.wt_index_i = 10'd9;
        bus.wt_brdir_i = 1'b1;
        drive_read(10'd9, 10'h003);
        bus.wt_en_i    = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (bus.rd_hist_vld_o !== 1'b1 || bus.rd_hist_o !== e) begin
            n_errors++;
            $display("FAIL bypass vld=%b hist=%h expected 1 %h", bus.rd_hist_vld_o, bus.rd_hist_o, e);
        end
        drive_read(10'd9, 10'h003);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.rd_hist_o !== e) begin
            n_errors++;
            $display("FAIL bypass_later hist=%h expected %h", bus.rd_hist_o, e);
        end
    endtask

    task automatic test_flush();
        int busy_cnt = 0;
        logic [HIST_W-1:0] e;
        for (int i = 0; i < 10; i++) begin
            drive_write(10'd0, 1'b1);
            drive_write(10'd1023, 1'b1);
        end
        drive_read(10'd0, 10'h3FF);
        drive_read(10'd1023, 10'h3FF);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (i == 1 && bus.rd_hist_o !== e) begin
                n_errors++;
                $display("FAIL fill_1023 hist=%h expected %h", bus.rd_hist_o, e);
            end
        end
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i    = 1'b0;
        bus.rd_vld_i   = 1'b1;
        bus.rd_index_i = 10'd0;
        bus.wt_en_i    = 1'b1;
        bus.wt_index_i = 10'd0;
        bus.wt_brdir_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy_o !== 1'b1) break;
            busy_cnt++;
            tick();
            n_checks++;
            if (bus.rd_hist_vld_o !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_read_vld cycle=%0d vld=%b expected 0", i, bus.rd_hist_vld_o);
            end
        end
        bus.rd_vld_i = 1'b0;
        bus.wt_en_i  = 1'b0;
        n_checks++;
        if (busy_cnt != 32) begin
            n_errors++;
            $display("FAIL flush_len busy_cycles=%0d expected 32", busy_cnt);
        end
        drive_read(10'd0, 10'h000);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.rd_hist_vld_o !== 1'b1 || bus.rd_hist_o !== e) begin
            n_errors++;
            $display("FAIL flushed_idx0 vld=%b hist=%h expected 1 %h", bus.rd_hist_vld_o, bus.rd_hist_o, e);
        end
        drive_read(10'd1023, 10'h000);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.rd_hist_o !== e) begin
            n_errors++;
            $display("FAIL flushed_idx1023 hist=%h expected %h", bus.rd_hist_o, e);
        end
    endtask

    task automatic test_flush_restart();
        int busy_cnt = 0;
        logic [HIST_W-1:0] e;
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy_o !== 1'b1) break;
            busy_cnt++;
            tick();
        end
        n_checks++;
        if (busy_cnt != 32) begin
            n_errors++;
            $display("FAIL restart_len busy_cycles=%0d expected 32", busy_cnt);
        end
        // reset mid-flush, with a read accepted in the flush-start cycle
        drive_write(10'd1023, 1'b1);
        bus.flush_i = 1'b1;
        drive_read(10'd1023, 10'h001);
        bus.flush_i = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (bus.busy_o !== 1'b1 || bus.rd_hist_vld_o !== 1'b1 || bus.rd_hist_o !== e) begin
            n_errors++;
            $display("FAIL flush_start busy=%b vld=%b hist=%h expected 1 1 %h",
                     bus.busy_o, bus.rd_hist_vld_o, bus.rd_hist_o, e);
        end
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.rd_hist_vld_o !== 1'b0 || bus.rd_hist_o !== 10'h000) begin
            n_errors++;
            $display("FAIL reset_midflush busy=%b vld=%b hist=%h expected 0 0 000",
                     bus.busy_o, bus.rd_hist_vld_o, bus.rd_hist_o);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 1024; i++) model[i] = '0;
        drive_read(10'd1023, 10'h000);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.rd_hist_vld_o !== 1'b1 || bus.rd_hist_o !== e) begin
            n_errors++;
            $display("FAIL reset_cleared vld=%b hist=%h expected 1 %h", bus.rd_hist_vld_o, bus.rd_hist_o, e);
        end
    endtask

    task automatic test_random();
        logic              rd, we, dir;
        logic [IDX_W-1:0]  ri, wi;
        logic [HIST_W-1:0] e;
        for (int c = 0; c < 300; c++) begin
            rd  = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            dir = 1'($urandom_range(0, 1));
            ri  = IDX_W'($urandom_range(0, 3) + ($urandom_range(0, 1) ? 32 : 0));
            wi  = IDX_W'($urandom_range(0, 3) + ($urandom_range(0, 1) ? 32 : 0));
            bus.rd_vld_i   = rd;
            bus.rd_index_i = ri;
            bus.wt_en_i    = we;
            bus.wt_index_i = wi;
            bus.wt_brdir_i = dir;
            if (rd) begin
                if (we && ri == wi) exp_q.push_back({model[ri][HIST_W-2:0], dir});
                else                exp_q.push_back(model[ri]);
            end
            if (we) model[wi] = {model[wi][HIST_W-2:0], dir};
            tick();
            n_checks++;
            if (rd) begin
                e = exp_q.pop_front();
                if (bus.rd_hist_vld_o !== 1'b1 || bus.rd_hist_o !== e) begin
                    n_errors++;
                    $display("FAIL random cyc=%0d idx=%0d vld=%b hist=%h expected 1 %h",
                             c, ri, bus.rd_hist_vld_o, bus.rd_hist_o, e);
                end
            end else if (bus.rd_hist_vld_o !== 1'b0) begin
                n_errors++;
                $display("FAIL random_idle cyc=%0d vld=%b expected 0", c, bus.rd_hist_vld_o);
            end
        end
        bus.rd_vld_i = 1'b0;
        bus.wt_en_i  = 1'b0;
    endtask

`ifdef BHT_PARITY_EN
    task automatic test_parity();
        bus.perr_inj_i = 1'b1;
        drive_write(10'd3, 1'b1);
        bus.perr_inj_i = 1'b0;
        drive_read(10'd3, 10'h000);
        void'(exp_q.pop_front());
        n_checks++;
        if (bus.rd_perr_o !== 1'b1 || bus.rd_hist_o !== 10'h000) begin
            n_errors++;
            $display("FAIL parity_inj perr=%b hist=%h expected 1 000", bus.rd_perr_o, bus.rd_hist_o);
        end
        drive_write(10'd3, 1'b0);
        drive_read(10'd3, 10'h002);
        n_checks++;
        if (bus.rd_perr_o !== 1'b0 || bus.rd_hist_o !== exp_q.pop_front()) begin
            n_errors++;
            $display("FAIL parity_clean perr=%b hist=%h expected 0 002", bus.rd_perr_o, bus.rd_hist_o);
        end
    endtask
`endif

    initial begin
        clock          = 1'b0;
        reset_n        = 1'b1;
        bus.rd_vld_i   = 1'b0;
        bus.rd_index_i = '0;
        bus.wt_en_i    = 1'b0;
        bus.wt_index_i = '0;
        bus.wt_brdir_i = 1'b0;
        bus.flush_i    = 1'b0;
`ifdef BHT_PARITY_EN
        bus.perr_inj_i = 1'b0;
`endif
        #2 reset_n = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_flush();
        test_flush_restart();
        test_random();
`ifdef BHT_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bht_lh_pipe.md
Name: bht_lh_pipe

Overview:
- Parametrised local-history Branch History Table (BHT) for the fetch stage.
- Read index comes from the speculative PC; the history comes out registered one cycle later and feeds PHT indexing.
- Commit-side updates shift the confirmed direction into the indexed entry.
- Generalises the fixed 1024x10 table: configurable depth, history length and power-gating group size, a pipelined read with write bypass, and a multi-cycle flush sequencer.

Parameters:
- IDX_W, 10, index width; table depth = 2**IDX_W entries.
- HIST_W, 10, history bits per entry; HIST_W >= 2.
- GRP_W, 5, log2 entries per write-enable group; GRP_W < IDX_W; number of groups NGRP = 2**(IDX_W-GRP_W).

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- rd_vld_i  in  1  read request this cycle
- rd_index_i  in  IDX_W  read index (speculative PC)
- rd_hist_o  out  HIST_W  history for the request of the previous cycle
- rd_hist_vld_o  out  1  rd_hist_o valid
- wt_en_i  in  1  commit shift-in enable
- wt_index_i  in  IDX_W  write index (committed PC)
- wt_brdir_i  in  1  confirmed direction (1 = taken)
- flush_i  in  1  start table clear (pulse)
- busy_o  out  1  flush in progress

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - all entries = 0, FSM = IDLE, flush counter = 0.
  - rd_hist_o = 0, rd_hist_vld_o = 0, busy_o = 0.
- Write, IDLE only: on a clock edge with wt_en_i = 1, entry[wt_index_i] <= {entry[HIST_W-2:0], wt_brdir_i}.
  - Only the group wt_index_i[IDX_W-1:GRP_W] is enabled; all other groups hold.
- Read, 1-cycle latency:
  - Cycle t, with rd_vld_i = 1 in IDLE: at edge t+1, rd_hist_o is registered and rd_hist_vld_o = 1.
  - If rd_vld_i = 0, rd_hist_vld_o = 0 and rd_hist_o holds its last value.
- Bypass: when a read and a write to the same index occur in the same cycle t, rd_hist_o at t+1 equals the post-update value {old[HIST_W-2:0], wt_brdir_i}.
  - No stale value is ever returned for a write that completed before or at the read cycle.
- FSM has two states, IDLE and CLEAR:
  - IDLE -> CLEAR when flush_i = 1; counter <= 0; busy_o = 1 from the next cycle.
  - In CLEAR, each cycle zeroes all 2**GRP_W entries of group[counter], then counter increments.
  - After group NGRP-1 is cleared -> IDLE. Flush takes exactly NGRP cycles (32 at default); busy_o falls in the following cycle.
  - flush_i in CLEAR restarts the counter at 0 and stays in CLEAR.
  - The counter is IDX_W-GRP_W bits wide and must not wrap past NGRP-1 while in CLEAR.
- While busy_o = 1:
  - writes are dropped;
  - reads are ignored (rd_hist_vld_o = 0 the next cycle).
- flush_i and wt_en_i in the same IDLE cycle: the write is dropped, and the flush takes priority.
- Reset asserted mid-flush: immediate return to IDLE with the whole table cleared.
- Entries are not readable combinationally; rd_hist_o changes only on clock edges or on reset.

Optional Feature:
- Macro BHT_PARITY_EN.
- Defined:
  - each entry stores an extra even-parity bit, computed on write and on flush (parity of 0 = 0).
  - Added input perr_inj_i (1): when set with wt_en_i, the stored parity is inverted.
  - Added output rd_perr_o (1), registered alongside rd_hist_vld_o: on a mismatch, rd_perr_o = 1 and rd_hist_o is forced to 0.
  - Bypassed reads use the freshly computed parity. Reset value 0.
- Undefined: no parity storage, no extra ports, and area equals the base design.

Decomposition:
- Package bht_pkg:
  - default IDX_W/HIST_W/GRP_W constants;
  - fsm state typedef (IDLE, CLEAR);
  - history shift function.
- One sub-module, bht_grp: one 2**GRP_W-entry group with local write enable, clear enable and shift logic, instantiated NGRP times by the top.

Test Plan:
- Reset, then read idx 5 -> next cycle rd_hist_vld_o = 1, rd_hist_o = 10'h000.
- Writes to idx 5 of 1,1,0 over 3 cycles, then read 5 -> rd_hist_o = 10'h006; reads of idx 6 and idx 37 -> 10'h000 (same-group and other-group isolation).
- With idx 9 = 10'h001, read and write (dir 1) idx 9 in the same cycle -> rd_hist_o = 10'h003 next cycle; a later read also gives 10'h003.
- Fill idx 0 and idx 1023 with 10'h3FF, pulse flush_i -> busy_o high for exactly 32 cycles; reads/writes in that window give no valid data and no update; afterwards both read 10'h000.
- Pulse flush_i at cycle 10 of a flush -> busy_o lasts 32 cycles from the restart; assert reset_n = 0 mid-flush -> busy_o = 0 and rd_hist_vld_o = 0 immediately.
- With BHT_PARITY_EN: write idx 3 with perr_inj_i = 1, then read 3 -> rd_perr_o = 1, rd_hist_o = 0; a clean write to idx 3 followed by a read clears the error.
